pc_gen: RTL and testbench
=========================

PC_GEN -- requirements
Module: pc_gen

Interface
REQ-001 Parameter XLEN, default 32, PC and target width in bits.
REQ-002 Parameter RESET_PC, default 0, PC value loaded on reset.
REQ-003 Parameter RAS_DEPTH, default 4, return-address-stack entries; power of two, at least 2.
REQ-004 Parameter INST_BYTES, default 4, sequential PC increment.
REQ-005 clk  in  1  clock; all state updates on rising edge.
REQ-006 rst  in  1  reset, asynchronous, active-high.
REQ-007 stall  in  1  hold PC; no architectural update except pending-redirect capture.
REQ-008 flush_valid  in  1  redirect request from a later stage.
REQ-009 flush_target  in  XLEN  redirect destination.
REQ-010 pred_valid  in  1  predicted PC-relative jump or branch taken at fetch.
REQ-011 pred_offset  in  XLEN  signed offset added to current pc.
REQ-012 call  in  1  current instruction is a call; push return address.
REQ-013 ret  in  1  current instruction is a return; pop target.
REQ-014 pc  out  XLEN  current fetch PC, registered.
REQ-015 redirect_pending  out  1  a flush has been captured during stall and not yet applied.
REQ-016 ras_count  out  clog2(RAS_DEPTH+1)  valid RAS entries.

Function
REQ-017 An update cycle is any rising edge with stall=0; on it pc SHALL load next_pc, so next_pc is visible on pc one cycle later.
REQ-018 next_pc priority, highest first: flush_valid -> flush_target; redirect_pending -> held target; ret and ras_count>0 -> RAS top; pred_valid -> pc+pred_offset; otherwise pc+INST_BYTES.
REQ-019 All additions SHALL be modulo 2^XLEN; targets SHALL be used verbatim, with no alignment masking.
REQ-020 With stall=1, pc SHALL hold; a flush_valid SHALL be latched into the held target, and redirect_pending SHALL be set on the next edge.
REQ-021 A newer flush during stall SHALL overwrite the held target; the last flush wins.
REQ-022 On the first update cycle, redirect_pending SHALL clear, and pc SHALL take flush_target if flush_valid is 1 that cycle, else the held target.
REQ-023 call, ret and pred_valid SHALL be ignored, with no RAS change, on any cycle with stall=1, flush_valid=1 or redirect_pending=1.
REQ-024 A push SHALL write pc+INST_BYTES at the top and increment ras_count, saturating at RAS_DEPTH.
REQ-025 A push into a full RAS SHALL overwrite the oldest entry as a circular buffer.
REQ-026 ret with ras_count=0 SHALL be ignored, and next_pc SHALL fall through to the pred/sequential rules.
REQ-027 call and ret together with ras_count>0: next_pc SHALL be the old top, the top SHALL be replaced by pc+INST_BYTES, and ras_count SHALL stay unchanged.
REQ-028 call and ret together with ras_count=0: the push only, and next_pc SHALL follow the pred/sequential rules.
REQ-029 A flush SHALL NOT modify RAS contents or ras_count.

Reset
REQ-030 While rst=1: pc=RESET_PC, redirect_pending=0, held target=0, ras_count=0, RAS pointer=0, all RAS entries=0.
REQ-031 Deassertion of rst SHALL take effect at the next rising edge; the first update yields pc=RESET_PC+INST_BYTES absent other requests.

Structure
REQ-032 Package pc_pkg SHALL hold the XLEN and INST_BYTES defaults and the next-PC-source enum: FLUSH, PENDING, RAS, PRED, SEQ.
REQ-033 Sub-module pc_ras SHALL implement the circular RAS, with push, pop, top and count.

Verification
REQ-034 Reset, then 3 free-running cycles -> pc 0x0, 0x4, 0x8, 0xC.
REQ-035 pc=0x100, stall=1 for 3 cycles with flush to 0x200 then 0x300 -> pc holds 0x100, redirect_pending=1; on release pc=0x300, pending=0.
REQ-036 call at pc 0x40, then pred jump, then ret at 0x80 -> next pc=0x44; ras_count 1->0.
REQ-037 RAS_DEPTH=4 with 5 calls at 0x10, 0x20, 0x30, 0x40, 0x50 -> ras_count=4; pops return 0x54, 0x44, 0x34, 0x24; a fifth ret falls to pc+4.
REQ-038 pc=0xFFFF_FFFC with sequential step -> pc=0x0; pred_offset=-8 at 0x10 -> pc=0x8.
REQ-039 flush and ret in the same cycle with ras_count=2 -> pc=flush_target, ras_count stays 2.

Source files
------------

// File: rtl/pc_pkg.sv
// Shared defaults and next-PC source encoding for the fetch PC generator.
package pc_pkg;
  localparam int unsigned PC_XLEN       = 32;
  localparam int unsigned PC_INST_BYTES = 4;

  typedef enum logic [2:0] {
    FLUSH,
    PENDING,
    RAS,
    PRED,
    SEQ
  } pc_src_e;
endpackage

// File: rtl/pc_gen_if.sv
// Request/response bundle between the fetch control (master) and pc_gen (slave).
interface pc_gen_if import pc_pkg::*; #(
  parameter int unsigned XLEN      = PC_XLEN,
  parameter int unsigned RAS_DEPTH = 4
);
  localparam int unsigned CNT_W = $clog2(RAS_DEPTH + 1);

  logic             stall;
  logic             flush_valid;
  logic [XLEN-1:0]  flush_target;
  logic             pred_valid;
  logic [XLEN-1:0]  pred_offset;
  logic             call;
  logic             ret;
  logic [XLEN-1:0]  pc;
  logic             redirect_pending;
  logic [CNT_W-1:0] ras_count;

  modport master (
    output stall, flush_valid, flush_target, pred_valid, pred_offset, call, ret,
    input  pc, redirect_pending, ras_count
  );

  modport slave (
    input  stall, flush_valid, flush_target, pred_valid, pred_offset, call, ret,
    output pc, redirect_pending, ras_count
  );
endinterface

// File: rtl/pc_ras.sv
// Circular return-address stack; a push into a full stack overwrites the oldest entry.
module pc_ras import pc_pkg::*; #(
  parameter int unsigned XLEN  = PC_XLEN,
  parameter int unsigned DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           push,
  input  logic                           pop,
  input  logic [XLEN-1:0]                push_data,
  output logic [XLEN-1:0]                top,
  output logic [$clog2(DEPTH + 1)-1:0]   count
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [XLEN-1:0]  mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] top_ptr;
  logic [CNT_W-1:0] count_q;
  logic             pop_ok;

  assign top_ptr = wr_ptr - PTR_W'(1);
  assign pop_ok  = pop && (count_q != '0);
  assign top     = mem[top_ptr];
  assign count   = count_q;

  // Push+pop replaces the top in place so the depth is unchanged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      count_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push && pop_ok) begin
      mem[top_ptr] <= push_data;
    end else if (push) begin
      mem[wr_ptr] <= push_data;
      wr_ptr      <= wr_ptr + PTR_W'(1);
      if (count_q != CNT_W'(DEPTH)) count_q <= count_q + CNT_W'(1);
    end else if (pop_ok) begin
      wr_ptr  <= top_ptr;
      count_q <= count_q - CNT_W'(1);
    end
  end
endmodule

// File: rtl/pc_gen.sv
// Fetch PC generator: flush/pending redirect, RAS return, predicted jump, or sequential step.
module pc_gen import pc_pkg::*; #(
  parameter int unsigned     XLEN       = PC_XLEN,
  parameter logic [XLEN-1:0] RESET_PC   = '0,
  parameter int unsigned     RAS_DEPTH  = 4,
  parameter int unsigned     INST_BYTES = PC_INST_BYTES
) (
  input logic      clk,
  input logic      rst,
  pc_gen_if.slave  bus
);
  localparam int unsigned CNT_W = $clog2(RAS_DEPTH + 1);

  logic [XLEN-1:0]  pc_q;
  logic [XLEN-1:0]  held_q;
  logic             pending_q;
  logic [XLEN-1:0]  seq_pc;
  logic [XLEN-1:0]  ras_top;
  logic [XLEN-1:0]  next_pc;
  logic [CNT_W-1:0] ras_cnt;
  logic             ras_nonempty;
  logic             blocked;
  logic             do_push;
  logic             do_pop;
  pc_src_e          src;

  assign seq_pc       = pc_q + XLEN'(INST_BYTES);
  assign ras_nonempty = (ras_cnt != '0);
  // Any redirect in flight or a stall suppresses speculative RAS/prediction activity.
  assign blocked      = bus.stall | bus.flush_valid | pending_q;
  assign do_push      = bus.call & ~blocked;
  assign do_pop       = bus.ret & ras_nonempty & ~blocked;

  always_comb begin
    src = SEQ;
    if (bus.flush_valid)               src = FLUSH;
    else if (pending_q)                src = PENDING;
    else if (bus.ret && ras_nonempty)  src = RAS;
    else if (bus.pred_valid)           src = PRED;

    next_pc = seq_pc;
    case (src)
      FLUSH:   next_pc = bus.flush_target;
      PENDING: next_pc = held_q;
      RAS:     next_pc = ras_top;
      PRED:    next_pc = pc_q + bus.pred_offset;
      default: next_pc = seq_pc;
    endcase
  end

  // During stall only a flush is captured; the first unstalled edge consumes it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q      <= RESET_PC;
      held_q    <= '0;
      pending_q <= 1'b0;
    end else if (bus.stall) begin
      if (bus.flush_valid) begin
        held_q    <= bus.flush_target;
        pending_q <= 1'b1;
      end
    end else begin
      pc_q      <= next_pc;
      pending_q <= 1'b0;
    end
  end

  pc_ras #(
    .XLEN  (XLEN),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .rst       (rst),
    .push      (do_push),
    .pop       (do_pop),
    .push_data (seq_pc),
    .top       (ras_top),
    .count     (ras_cnt)
  );

  assign bus.pc               = pc_q;
  assign bus.redirect_pending = pending_q;
  assign bus.ras_count        = ras_cnt;
endmodule

// File: tb/tb_pc_gen.sv
// Directed bench for pc_gen: stimulus queues expected state, a monitor compares after each edge.
module tb_pc_gen;
  logic clk;
  logic rst;

  pc_gen_if #(.XLEN(32), .RAS_DEPTH(4)) bus ();

  pc_gen #(
    .XLEN       (32),
    .RESET_PC   (32'h0),
    .RAS_DEPTH  (4),
    .INST_BYTES (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    string       nm;
    logic [31:0] pc;
    logic        pend;
    logic [2:0]  cnt;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input string fld, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s.%s: got %h want %h", nm, fld, act, want);
    end
  endtask

  // Drive one cycle of inputs at negedge and queue the state expected after the next posedge.
  task automatic cyc(input string nm, input logic st, input logic fv, input logic [31:0] ft,
                     input logic pv, input logic [31:0] po, input logic c, input logic r,
                     input logic [31:0] epc, input logic epend, input logic [2:0] ecnt);
    exp_t e;
    @(negedge clk);
    bus.stall        = st;
    bus.flush_valid  = fv;
    bus.flush_target = ft;
    bus.pred_valid   = pv;
    bus.pred_offset  = po;
    bus.call         = c;
    bus.ret          = r;
    e.nm   = nm;
    e.pc   = epc;
    e.pend = epend;
    e.cnt  = ecnt;
    exp_q.push_back(e);
  endtask

  task automatic seq(input string nm, input logic [31:0] epc, input logic [2:0] ecnt);
    cyc(nm, 0, 0, 0, 0, 0, 0, 0, epc, 0, ecnt);
  endtask

  task automatic fl(input string nm, input logic [31:0] tgt, input logic [2:0] ecnt);
    cyc(nm, 0, 1, tgt, 0, 0, 0, 0, tgt, 0, ecnt);
  endtask

  task automatic call_c(input string nm, input logic [31:0] epc, input logic [2:0] ecnt);
    cyc(nm, 0, 0, 0, 0, 0, 1, 0, epc, 0, ecnt);
  endtask

  task automatic ret_c(input string nm, input logic [31:0] epc, input logic [2:0] ecnt);
    cyc(nm, 0, 0, 0, 0, 0, 0, 1, epc, 0, ecnt);
  endtask

  // Monitor: compare one queued expectation shortly after each rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk(e.nm, "pc",      bus.pc,                       e.pc);
        chk(e.nm, "pending", {31'b0, bus.redirect_pending}, {31'b0, e.pend});
        chk(e.nm, "count",   {29'b0, bus.ras_count},        {29'b0, e.cnt});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst              = 1'b1;
    bus.stall        = 1'b0;
    bus.flush_valid  = 1'b0;
    bus.flush_target = '0;
    bus.pred_valid   = 1'b0;
    bus.pred_offset  = '0;
    bus.call         = 1'b0;
    bus.ret          = 1'b0;

    seq("reset", 32'h0, 0);
    @(posedge clk);
    #2 rst = 1'b0;

    seq("run1", 32'h4, 0);
    seq("run2", 32'h8, 0);
    seq("run3", 32'hC, 0);

    fl("set_top", 32'hFFFF_FFFC, 0);
    seq("wrap", 32'h0, 0);
    fl("set_10", 32'h10, 0);
    cyc("pred_neg", 0, 0, 0, 1, 32'hFFFF_FFF8, 0, 0, 32'h8, 0, 0);

    fl("set_100", 32'h100, 0);
    cyc("stall_f200", 1, 1, 32'h200, 0, 0, 0, 0, 32'h100, 1, 0);
    cyc("stall_hold", 1, 0, 0,       0, 0, 0, 0, 32'h100, 1, 0);
    cyc("stall_f300", 1, 1, 32'h300, 0, 0, 0, 0, 32'h100, 1, 0);
    seq("release", 32'h300, 0);
    seq("after_rel", 32'h304, 0);
    cyc("stall_f500", 1, 1, 32'h500, 0, 0, 0, 0, 32'h304, 1, 0);
    cyc("rel_f600",   0, 1, 32'h600, 0, 0, 0, 0, 32'h600, 0, 0);
    cyc("stall_f700", 1, 1, 32'h700, 0, 0, 0, 0, 32'h600, 1, 0);
    cyc("rel_call",   0, 0, 0,       0, 0, 1, 0, 32'h700, 0, 0);

    fl("set_40", 32'h40, 0);
    cyc("call_pred", 0, 0, 0, 1, 32'h40, 1, 0, 32'h80, 0, 1);
    ret_c("ret_80", 32'h44, 0);

    fl("set_a10", 32'h10, 0);
    call_c("call_10", 32'h14, 1);
    fl("set_a20", 32'h20, 1);
    call_c("call_20", 32'h24, 2);
    fl("set_a30", 32'h30, 2);
    call_c("call_30", 32'h34, 3);
    fl("set_a40", 32'h40, 3);
    call_c("call_40", 32'h44, 4);
    fl("set_a50", 32'h50, 4);
    call_c("call_50", 32'h54, 4);
    ret_c("pop1", 32'h54, 3);
    ret_c("pop2", 32'h44, 2);
    ret_c("pop3", 32'h34, 1);
    ret_c("pop4", 32'h24, 0);
    ret_c("pop_empty", 32'h28, 0);

    call_c("call_28", 32'h2C, 1);
    fl("set_90", 32'h90, 1);
    cyc("call_ret", 0, 0, 0, 0, 0, 1, 1, 32'h2C, 0, 1);
    ret_c("ret_repl", 32'h94, 0);
    cyc("call_ret_empty", 0, 0, 0, 1, 32'h10, 1, 1, 32'hA4, 0, 1);
    ret_c("ret_98", 32'h98, 0);

    call_c("call_98", 32'h9C, 1);
    call_c("call_9c", 32'hA0, 2);
    cyc("flush_ret", 0, 1, 32'h1000, 0, 0, 0, 1, 32'h1000, 0, 2);
    ret_c("ret_a0", 32'hA0, 1);
    ret_c("ret_9c", 32'h9C, 0);

    cyc("stall_call", 1, 0, 0, 0, 0, 1, 0, 32'h9C, 0, 0);
    seq("post_stall", 32'hA0, 0);

    @(negedge clk);
    bus.call = 1'b0;
    bus.ret  = 1'b0;
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: got %0d pending want 0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
